// File: rtl/strobe_pkg.sv
// Shared types and constants for the multi-channel strobe converter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package strobe_pkg;

    // Per-channel edge selection: bit0 enables rising, bit1 enables falling.
    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_OFF  = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

    // True when the mode accepts a transition in the given direction.
    function automatic logic mode_accepts(input edge_mode_t mode, input logic rising);
        if (mode == MODE_OFF)
            return 1'b0;
        else if (rising)
            return (mode == MODE_RISE) || (mode == MODE_BOTH);
        else
            return (mode == MODE_FALL) || (mode == MODE_BOTH);
    endfunction

endpackage

// File: rtl/strobe_channel.sv
// One channel: synchroniser, debounce filter, edge qualifier, retriggerable stretcher, overrun flag.
// Latency: SYNC_STAGES + FILTER_CYCLES - 1 edges from first sync capture to level/strobe update.
// Backpressure: none; strobes are free-running and retrigger sets the sticky overrun flag.
module strobe_channel
    import strobe_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int PULSE_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  edge_mode_t mode,
    input  logic       clear_overrun,
    output logic       strobe,
    output logic       level,
    output logic       overrun
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          filt_cnt;
    logic                   level_q;
    logic [PW-1:0]          pulse_cnt;
    logic                   overrun_q;
    logic                   synced;
    logic                   toggle;
    logic                   qual_event;

    assign synced = sync_q[SYNC_STAGES-1];

    // Level flips once the synced value has differed for FILTER_CYCLES consecutive cycles.
    assign toggle = (synced != level_q) && (filt_cnt == FW'(FILTER_CYCLES - 1));

    // Direction of the event is the direction the level is about to move.
    assign qual_event = toggle && mode_accepts(mode, ~level_q);

    // Shift the raw input through the synchroniser; stage 0 sees the raw pin.
    always_ff @(posedge clk) begin
        if (reset)
            sync_q <= '0;
        else
            sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
    end

    // Debounce: count cycles of disagreement, any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt <= '0;
            level_q  <= 1'b0;
        end else if (synced == level_q) begin
            filt_cnt <= '0;
        end else if (toggle) begin
            filt_cnt <= '0;
            level_q  <= ~level_q;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // Stretcher: load on every qualifying event, otherwise count down to idle.
    always_ff @(posedge clk) begin
        if (reset)
            pulse_cnt <= '0;
        else if (qual_event)
            pulse_cnt <= PW'(PULSE_CYCLES);
        else if (pulse_cnt != '0)
            pulse_cnt <= pulse_cnt - PW'(1);
    end

    // Sticky overrun: a retrigger sets it and takes priority over a clear.
    always_ff @(posedge clk) begin
        if (reset)
            overrun_q <= 1'b0;
        else
            overrun_q <= (qual_event && (pulse_cnt != '0)) || (overrun_q && !clear_overrun);
    end

    assign strobe  = (pulse_cnt != '0);
    assign level   = level_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/multi_strobe_converter.sv
// Multi-channel level-to-strobe converter; one independent strobe_channel per input bit.
// Latency: SYNC_STAGES + FILTER_CYCLES - 1 edges from first sync capture to level/strobe update.
// Backpressure: none; consumers must accept strobes as issued, overlaps flagged via overrun.
module multi_strobe_converter
    import strobe_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int PULSE_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] edge_mode,
    input  logic                  clear_overrun,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   overrun
);

    // Slice the packed buses into one channel instance per bit.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        strobe_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .PULSE_CYCLES  (PULSE_CYCLES)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .din           (in[i]),
            .mode          (edge_mode_t'(edge_mode[2*i +: 2])),
            .clear_overrun (clear_overrun),
            .strobe        (out[i]),
            .level         (level[i]),
            .overrun       (overrun[i])
        );
    end

endmodule

// File: tb/tb_multi_strobe_converter.sv
// Scoreboard bench: stimulus pushes hand-computed output snapshots with their edge number,
// monitors pop and compare whenever a DUT's outputs change.
// dut_a uses defaults (PULSE_CYCLES=1); dut_b uses PULSE_CYCLES=8.
module tb_multi_strobe_converter;

    typedef struct {
        int         cyc;
        logic [11:0] val;   // {overrun, level, out}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic [3:0] in_a = 4'b1000, in_b = 4'b0000;
    logic [7:0] mode_a = 8'b01_00_11_01;
    logic [7:0] mode_b = 8'b00_00_11_11;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [3:0] out_a, lvl_a, ov_a, out_b, lvl_b, ov_b;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;
    logic [11:0] prev_a, prev_b;
    exp_t q_a[$];
    exp_t q_b[$];

    multi_strobe_converter dut_a (
        .clk(clk), .reset(rst_a), .in(in_a), .edge_mode(mode_a),
        .clear_overrun(clr_a), .out(out_a), .level(lvl_a), .overrun(ov_a)
    );

    multi_strobe_converter #(.PULSE_CYCLES(8)) dut_b (
        .clk(clk), .reset(rst_b), .in(in_b), .edge_mode(mode_b),
        .clear_overrun(clr_b), .out(out_b), .level(lvl_b), .overrun(ov_b)
    );

    always #5 clk = ~clk;

    // Edge counter: at the negedge following posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic void push_a(input int c, input logic [3:0] ov, input logic [3:0] lv, input logic [3:0] o);
        exp_t e;
        e.cyc = c;
        e.val = {ov, lv, o};
        q_a.push_back(e);
    endfunction

    function automatic void push_b(input int c, input logic [3:0] ov, input logic [3:0] lv, input logic [3:0] o);
        exp_t e;
        e.cyc = c;
        e.val = {ov, lv, o};
        q_b.push_back(e);
    endfunction

    // Monitor A: every output change must match the next expected snapshot.
    always @(negedge clk) begin
        logic [11:0] snap;
        exp_t e;
        if (mon_en) begin
            snap = {ov_a, lvl_a, out_a};
            if (snap !== prev_a) begin
                tests++;
                if (q_a.size() == 0) begin
                    fails++;
                    $display("FAIL a_unexpected cyc=%0d got ov/lvl/out=%b required no change", cyc, snap);
                end else begin
                    e = q_a.pop_front();
                    if (e.cyc != cyc || e.val !== snap) begin
                        fails++;
                        $display("FAIL a_event cyc=%0d got ov/lvl/out=%b required cyc=%0d ov/lvl/out=%b",
                                 cyc, snap, e.cyc, e.val);
                    end
                end
                prev_a = snap;
            end
        end
    end

    // Monitor B: same checking for the long-pulse instance.
    always @(negedge clk) begin
        logic [11:0] snap;
        exp_t e;
        if (mon_en) begin
            snap = {ov_b, lvl_b, out_b};
            if (snap !== prev_b) begin
                tests++;
                if (q_b.size() == 0) begin
                    fails++;
                    $display("FAIL b_unexpected cyc=%0d got ov/lvl/out=%b required no change", cyc, snap);
                end else begin
                    e = q_b.pop_front();
                    if (e.cyc != cyc || e.val !== snap) begin
                        fails++;
                        $display("FAIL b_event cyc=%0d got ov/lvl/out=%b required cyc=%0d ov/lvl/out=%b",
                                 cyc, snap, e.cyc, e.val);
                    end
                end
                prev_b = snap;
            end
        end
    end

    initial begin
        wait_cyc(10);
        // Reset state of both instances.
        tests++;
        if ({ov_a, lvl_a, out_a} !== 12'h000) begin
            fails++;
            $display("FAIL a_reset got %b required 000000000000", {ov_a, lvl_a, out_a});
        end
        tests++;
        if ({ov_b, lvl_b, out_b} !== 12'h000) begin
            fails++;
            $display("FAIL b_reset got %b required 000000000000", {ov_b, lvl_b, out_b});
        end
        prev_a = {ov_a, lvl_a, out_a};
        prev_b = {ov_b, lvl_b, out_b};
        mon_en = 1'b1;
        rst_a  = 1'b0;
        rst_b  = 1'b0;

        fork
            begin : stim_a
                // ch3 held high through reset, mode 01: strobe at 11+5.
                push_a(16, 4'b0000, 4'b1000, 4'b1000);
                push_a(17, 4'b0000, 4'b1000, 4'b0000);
                // ch0 mode 01: rise strobes, fall only moves level.
                wait_cyc(20); in_a[0] = 1'b1;
                push_a(26, 4'b0000, 4'b1001, 4'b0001);
                push_a(27, 4'b0000, 4'b1001, 4'b0000);
                wait_cyc(30); in_a[0] = 1'b0;
                push_a(36, 4'b0000, 4'b1000, 4'b0000);
                // ch1: 3-cycle glitch is rejected, then a held rise is accepted.
                wait_cyc(40); in_a[1] = 1'b1;
                wait_cyc(43); in_a[1] = 1'b0;
                wait_cyc(50); in_a[1] = 1'b1;
                push_a(56, 4'b0000, 4'b1010, 4'b0010);
                push_a(57, 4'b0000, 4'b1010, 4'b0000);
                // ch2 mode 00: level tracks both ways, never strobes.
                wait_cyc(60); in_a[2] = 1'b1;
                push_a(66, 4'b0000, 4'b1110, 4'b0000);
                wait_cyc(70); in_a[2] = 1'b0;
                push_a(76, 4'b0000, 4'b1010, 4'b0000);
                // Reset mid-filter on ch0; held-high ch0/1/3 re-fire after release.
                wait_cyc(80); in_a[0] = 1'b1;
                wait_cyc(83); rst_a = 1'b1;
                push_a(84, 4'b0000, 4'b0000, 4'b0000);
                wait_cyc(85); rst_a = 1'b0;
                push_a(91, 4'b0000, 4'b1011, 4'b1011);
                push_a(92, 4'b0000, 4'b1011, 4'b0000);
            end
            begin : stim_b
                // ch0 mode 11: rise and fall 10 cycles apart, two 8-cycle strobes.
                wait_cyc(20); in_b[0] = 1'b1;
                push_b(26, 4'b0000, 4'b0001, 4'b0001);
                push_b(34, 4'b0000, 4'b0001, 4'b0000);
                wait_cyc(30); in_b[0] = 1'b0;
                push_b(36, 4'b0000, 4'b0000, 4'b0001);
                push_b(44, 4'b0000, 4'b0000, 4'b0000);
                // ch1: accepted edges 5 apart retrigger, out continuous 56..68.
                wait_cyc(50); in_b[1] = 1'b1;
                push_b(56, 4'b0000, 4'b0010, 4'b0010);
                wait_cyc(55); in_b[1] = 1'b0;
                push_b(61, 4'b0010, 4'b0000, 4'b0010);
                // Further retrigger with a simultaneous clear: set wins.
                wait_cyc(60); in_b[1] = 1'b1;
                push_b(66, 4'b0010, 4'b0010, 4'b0010);
                push_b(74, 4'b0010, 4'b0010, 4'b0000);
                wait_cyc(65); clr_b = 1'b1;
                wait_cyc(66); clr_b = 1'b0;
                // Lone clear.
                wait_cyc(78); clr_b = 1'b1;
                push_b(79, 4'b0000, 4'b0010, 4'b0000);
                wait_cyc(79); clr_b = 1'b0;
                // Reset mid-strobe on ch0 and mid-filter on ch1.
                wait_cyc(90); in_b[0] = 1'b1;
                push_b(96, 4'b0000, 4'b0011, 4'b0001);
                wait_cyc(95); in_b[1] = 1'b0;
                wait_cyc(98); rst_b = 1'b1;
                push_b(99, 4'b0000, 4'b0000, 4'b0000);
                wait_cyc(99); rst_b = 1'b0;
                push_b(105, 4'b0000, 4'b0001, 4'b0001);
                push_b(113, 4'b0000, 4'b0001, 4'b0000);
            end
        join

        wait_cyc(125);
        // Every expected event must have been observed.
        tests++;
        if (q_a.size() != 0) begin
            fails++;
            $display("FAIL a_missing got %0d pending events required 0 (next cyc=%0d)", q_a.size(), q_a[0].cyc);
        end
        tests++;
        if (q_b.size() != 0) begin
            fails++;
            $display("FAIL b_missing got %0d pending events required 0 (next cyc=%0d)", q_b.size(), q_b[0].cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
